// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared FSM state type and idle output constants for game_switcher
// Contents:
//   state_e : MENU / BLANK_IN / GAME / BLANK_OUT
//   CLR_AN  : anode value that blanks the 7-segment display (all ones)
//   CLR_SEG : segment value that blanks the 7-segment display (all ones)
//   BLACK   : OLED pixel value shown while blanking (all zeros)
package game_pkg;

  typedef enum logic [1:0] {
    ST_MENU      = 2'd0,
    ST_BLANK_IN  = 2'd1,
    ST_GAME      = 2'd2,
    ST_BLANK_OUT = 2'd3
  } state_e;

  localparam logic [3:0]  CLR_AN  = 4'hF;
  localparam logic [7:0]  CLR_SEG = 8'hFF;
  localparam logic [15:0] BLACK   = 16'h0000;

endpackage

// File: rtl/game_switcher_btn_rise.sv
// rtl/game_switcher_btn_rise.sv - rising-edge detector for an already-synchronised button level
// Ports:
//   clk   in  : clock, rising edge
//   reset in  : synchronous active-high reset
//   btn   in  : button level
//   rise  out : high for the cycle where btn is high and was low one cycle earlier
// RESET_VAL = 1 makes a button that is already held at reset release produce no edge.
module btn_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;
  logic btn_d;

  always_comb begin
    btn_d = btn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= RESET_VAL;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/game_switcher.sv
// rtl/game_switcher.sv - routes menu or one of N game sources to the display pins with blanking between
// Ports:
//   basys_clock in  : system clock, rising edge
//   reset       in  : synchronous active-high reset
//   btn_enter   in  : level; rising edge selects the game under sel_idx
//   btn_back    in  : level; rising edge returns to the menu
//   sel_idx     in  : menu cursor, 1..N_GAMES legal
//   oled_menu   in  : menu pixel
//   an_games    in  : flattened anode buses, game i in slice i-1
//   seg_games   in  : flattened segment buses, same slicing
//   oled_games  in  : flattened pixel buses, same slicing
//   an          out : registered anode output
//   seg         out : registered segment output
//   oled_data   out : registered pixel output
//   game_en     out : one-hot enable of the active game (BLANK_IN and GAME only)
//   progress    out : 0 in the menu, otherwise the active game index
module game_switcher #(
  parameter int                 N_GAMES      = 3,
  parameter int                 BLANK_CYCLES = 4,
  parameter int                 AN_W         = 4,
  parameter int                 SEG_W        = 8,
  parameter int                 OLED_W       = 16,
  parameter logic [AN_W-1:0]    CLR_AN       = game_pkg::CLR_AN,
  parameter logic [SEG_W-1:0]   CLR_SEG      = game_pkg::CLR_SEG,
  parameter logic [OLED_W-1:0]  BLACK        = game_pkg::BLACK
) (
  input  logic                              basys_clock,
  input  logic                              reset,
  input  logic                              btn_enter,
  input  logic                              btn_back,
  input  logic [$clog2(N_GAMES+1)-1:0]      sel_idx,
  input  logic [OLED_W-1:0]                 oled_menu,
  input  logic [N_GAMES*AN_W-1:0]           an_games,
  input  logic [N_GAMES*SEG_W-1:0]          seg_games,
  input  logic [N_GAMES*OLED_W-1:0]         oled_games,
  output logic [AN_W-1:0]                   an,
  output logic [SEG_W-1:0]                  seg,
  output logic [OLED_W-1:0]                 oled_data,
  output logic [N_GAMES-1:0]                game_en,
  output logic [$clog2(N_GAMES+1)-1:0]      progress
);

  import game_pkg::*;

  localparam int IW      = $clog2(N_GAMES + 1);
  localparam int CW      = $clog2(BLANK_CYCLES + 1);
  localparam int AN_IW   = (N_GAMES * AN_W   > 1) ? $clog2(N_GAMES * AN_W)   : 1;
  localparam int SEG_IW  = (N_GAMES * SEG_W  > 1) ? $clog2(N_GAMES * SEG_W)  : 1;
  localparam int OLED_IW = (N_GAMES * OLED_W > 1) ? $clog2(N_GAMES * OLED_W) : 1;

  localparam logic [IW-1:0] MAX_SEL  = IW'(N_GAMES);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLANK_CYCLES - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       cur_q, cur_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AN_W-1:0]     an_q, an_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [OLED_W-1:0]   oled_q, oled_d;

  logic                enter_rise;
  logic                back_rise;
  logic                sel_ok;
  logic [IW-1:0]       slot;
  logic [AN_IW-1:0]    an_base;
  logic [SEG_IW-1:0]   seg_base;
  logic [OLED_IW-1:0]  oled_base;

  btn_rise #(.RESET_VAL(1'b1)) u_enter_rise (
    .clk   (basys_clock),
    .reset (reset),
    .btn   (btn_enter),
    .rise  (enter_rise)
  );

  btn_rise #(.RESET_VAL(1'b1)) u_back_rise (
    .clk   (basys_clock),
    .reset (reset),
    .btn   (btn_back),
    .rise  (back_rise)
  );

  assign sel_ok = (sel_idx != '0) && (sel_idx <= MAX_SEL);

  // Zero-based slice of the active game; only meaningful while cur_q != 0.
  assign slot      = cur_q - 1'b1;
  assign an_base   = AN_IW'(slot * AN_W);
  assign seg_base  = SEG_IW'(slot * SEG_W);
  assign oled_base = OLED_IW'(slot * OLED_W);

  // State register plus the registered display outputs.
  always_ff @(posedge basys_clock) begin
    if (reset) begin
      state_q <= ST_MENU;
      cur_q   <= '0;
      cnt_q   <= '0;
      an_q    <= CLR_AN;
      seg_q   <= CLR_SEG;
      oled_q  <= BLACK;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      oled_q  <= oled_d;
    end
  end

  // Next-state logic. Each state only looks at the button that matters to it,
  // which gives enter priority in MENU and back priority in GAME, and makes
  // both BLANK states deaf to buttons.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_MENU: begin
        if (enter_rise && sel_ok) begin
          cur_d   = sel_idx;
          cnt_d   = '0;
          state_d = ST_BLANK_IN;
        end
      end
      ST_BLANK_IN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_GAME;
        end
      end
      ST_GAME: begin
        if (back_rise) begin
          cnt_d   = '0;
          state_d = ST_BLANK_OUT;
        end
      end
      ST_BLANK_OUT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cur_d   = '0;
          state_d = ST_MENU;
        end
      end
      default: begin
        state_d = ST_MENU;
        cur_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output selection from the current state; the display values go through
  // the output registers so a source change shows one cycle later.
  always_comb begin
    an_d     = CLR_AN;
    seg_d    = CLR_SEG;
    oled_d   = BLACK;
    game_en  = '0;
    progress = cur_q;
    case (state_q)
      ST_MENU: begin
        oled_d = oled_menu;
      end
      ST_BLANK_IN: begin
        game_en = N_GAMES'(1) << slot;
      end
      ST_GAME: begin
        an_d    = an_games[an_base +: AN_W];
        seg_d   = seg_games[seg_base +: SEG_W];
        oled_d  = oled_games[oled_base +: OLED_W];
        game_en = N_GAMES'(1) << slot;
      end
      default: begin
      end
    endcase
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign oled_data = oled_q;

endmodule
